// File: rtl/inst_fetcher.sv
// Instruction fetcher with a direct-mapped one-word-per-line icache and static
// branch prediction (JAL taken, backward conditional branches taken).
module inst_fetcher #(
    parameter int unsigned ICACHE_IDX_W = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        stall,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_predict_jump
);

    localparam int unsigned LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic {FETCH, WAIT_MEM} state_t;

    state_t                  state, state_next;
    logic [31:0]             pc, pc_next;
    logic                    mem_req_next;
    logic [31:0]             mem_addr_next;
    logic                    inst_valid_next;
    logic [31:0]             inst_next, inst_pc_next;
    logic                    predict_next;
    logic                    fill;

    logic [LINES-1:0]        line_valid;
    logic [TAG_W-1:0]        line_tag  [LINES];
    logic [31:0]             line_data [LINES];

    logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;
    logic                    hit;
    logic [31:0]             hit_word;

    assign pc_idx   = pc[ICACHE_IDX_W+1:2];
    assign pc_tag   = pc[31:ICACHE_IDX_W+2];
    assign fill_idx = mem_addr[ICACHE_IDX_W+1:2];
    assign fill_tag = mem_addr[31:ICACHE_IDX_W+2];
    assign hit_word = line_data[pc_idx];
    assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);

    logic [31:0] j_imm, b_imm, pred_target;
    logic        pred_taken;

    assign j_imm = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
    assign b_imm = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

    // Backward branches (negative offset) are predicted taken; JALR is never predicted.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc + 32'd4;
        if (hit_word[6:0] == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc + j_imm;
        end else if (hit_word[6:0] == OP_BRANCH && hit_word[31]) begin
            pred_taken  = 1'b1;
            pred_target = pc + b_imm;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        mem_req_next    = mem_req;
        mem_addr_next   = mem_addr;
        inst_valid_next = 1'b0;
        inst_next       = inst;
        inst_pc_next    = inst_pc;
        predict_next    = inst_predict_jump;
        fill            = 1'b0;
        case (state)
            FETCH: begin
                if (rollback) begin
                    pc_next = rollback_pc;
                end else if (hit) begin
                    if (!stall) begin
                        inst_valid_next = 1'b1;
                        inst_next       = hit_word;
                        inst_pc_next    = pc;
                        predict_next    = pred_taken;
                        pc_next         = pred_target;
                    end
                end else begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc;
                    state_next    = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // The outstanding request always completes; rollback only retargets pc.
                if (rollback) pc_next = rollback_pc;
                if (mem_done) begin
                    fill         = 1'b1;
                    mem_req_next = 1'b0;
                    state_next   = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            line_valid        <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= 32'h0;
            inst_valid        <= 1'b0;
            inst              <= 32'h0;
            inst_pc           <= 32'h0;
            inst_predict_jump <= 1'b0;
        end else if (rdy) begin
            state             <= state_next;
            pc                <= pc_next;
            mem_req           <= mem_req_next;
            mem_addr          <= mem_addr_next;
            inst_valid        <= inst_valid_next;
            inst              <= inst_next;
            inst_pc           <= inst_pc_next;
            inst_predict_jump <= predict_next;
            if (fill) line_valid[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && rdy && fill) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem_data;
        end
    end

endmodule
